// File: rtl/kgp_mem_pkg.sv
// Shared definitions for the KGP-RISC data memory path: access size codes,
// controller FSM encoding and the size-to-byte-length helper.
package kgp_mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        logic [3:0] n;
        case (sz)
            SZ_B:    n = 4'd1;
            SZ_H:    n = 4'd2;
            SZ_W:    n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/kgp_mem_array.sv
// Single-port data RAM with per-byte-lane write mask and a registered read port.
// Contents are never reset.
module kgp_mem_array #(
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   wmask,
    input  logic [DEPTH_W-1:0]    addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    output logic [DATA_W-1:0]     rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [2**DEPTH_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we && wmask[i]) begin
                mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/kgp_data_mem_ctrl.sv
// Load/store controller for the KGP-RISC data RAM: request/done handshake,
// sub-word lane steering, sign/zero extension, alignment checks, 1..4 cycle load latency.
module kgp_data_mem_ctrl
    import kgp_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 10,
    parameter int RD_LAT  = 1
) (
    input  logic                                   clka,
    input  logic                                   rsta,
    input  logic                                   req,
    input  logic                                   we,
    input  logic [1:0]                             size,
    input  logic                                   sext,
    input  logic [DEPTH_W+$clog2(DATA_W/8)-1:0]    addra,
    input  logic [DATA_W-1:0]                      dina,
    output logic                                   ready,
    output logic                                   done,
    output logic                                   err,
    output logic [DATA_W-1:0]                      douta
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int AW    = DEPTH_W + OFF_W;

    function automatic logic access_bad(input logic [1:0] sz, input logic [OFF_W-1:0] off);
        logic [3:0] n;
        n = size_bytes(sz);
        if (DATA_W == 32 && sz == SZ_D) begin
            return 1'b1;
        end
        return (4'(off) & (n - 4'd1)) != 4'd0;
    endfunction

    function automatic logic [NB-1:0] lane_mask(input logic [1:0] sz, input logic [OFF_W-1:0] off);
        logic [NB-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(size_bytes(sz))) begin
                m[i] = 1'b1;
            end
        end
        return m << off;
    endfunction

    // Right-align the addressed lanes, then fill above the access width with the sign or zeros.
    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] word,
                                                      input logic [1:0]        sz,
                                                      input logic [OFF_W-1:0]  off,
                                                      input logic              sx);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] res;
        int                nbits;
        sh    = word >> {off, 3'b000};
        nbits = 8 * int'(size_bytes(sz));
        if (nbits >= DATA_W) begin
            return sh;
        end
        res = sh;
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= nbits) begin
                res[i] = sx & sh[nbits-1];
            end
        end
        return res;
    endfunction

    mem_state_e        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              bad_q, bad_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] douta_q, douta_d;

    logic              accept;
    logic [OFF_W-1:0]  req_off;
    logic              req_bad;
    logic              mem_we;
    logic [NB-1:0]     mem_mask;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    assign accept    = (state_q == ST_IDLE) && req;
    assign req_off   = addra[OFF_W-1:0];
    assign req_bad   = access_bad(size, req_off);
    // Stores commit on the acceptance edge so the RAM sees the live request, not the latched copy.
    assign mem_we    = accept && we && !req_bad;
    assign mem_mask  = lane_mask(size, req_off);
    assign mem_wdata = dina << {req_off, 3'b000};

    kgp_mem_array #(
        .DATA_W  (DATA_W),
        .DEPTH_W (DEPTH_W)
    ) u_array (
        .clk   (clka),
        .we    (mem_we),
        .wmask (mem_mask),
        .addr  (addra[AW-1:OFF_W]),
        .wdata (mem_wdata),
        .re    (accept),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        off_d   = off_q;
        bad_d   = bad_q;
        done_d  = 1'b0;
        err_d   = err_q;
        douta_d = douta_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d   = we;
                    size_d = size;
                    sext_d = sext;
                    off_d  = req_off;
                    bad_d  = req_bad;
                    if (we || req_bad || RD_LAT == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 2'(RD_LAT - 2);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_RESP: begin
                // Leaving RESP is the edge that raises done and updates err/douta together.
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
                done_d  = 1'b1;
                if (bad_q) begin
                    err_d   = 1'b1;
                    douta_d = '0;
                end else begin
                    err_d = 1'b0;
                    if (!we_q) begin
                        douta_d = extend_load(mem_rdata, size_q, off_q, sext_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            sext_q  <= 1'b0;
            off_q   <= '0;
            bad_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            douta_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            off_q   <= off_d;
            bad_q   <= bad_d;
            done_q  <= done_d;
            err_q   <= err_d;
            douta_q <= douta_d;
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign done  = done_q;
    assign err   = err_q;
    assign douta = douta_q;

endmodule

// File: tb/tb_kgp_data_mem_ctrl.sv
// Scoreboard bench for kgp_data_mem_ctrl (32-bit data, load latency 2).
module tb_kgp_data_mem_ctrl;

    localparam int TB_LAT = 2;

    logic        clka = 1'b0;
    logic        rsta = 1'b1;
    logic        req  = 1'b0;
    logic        we   = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sext = 1'b0;
    logic [11:0] addra = '0;
    logic [31:0] dina  = '0;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] douta;

    kgp_data_mem_ctrl #(
        .DATA_W  (32),
        .DEPTH_W (10),
        .RD_LAT  (TB_LAT)
    ) dut (
        .clka  (clka),
        .rsta  (rsta),
        .req   (req),
        .we    (we),
        .size  (size),
        .sext  (sext),
        .addra (addra),
        .dina  (dina),
        .ready (ready),
        .done  (done),
        .err   (err),
        .douta (douta)
    );

    always #5 clka = ~clka;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          acc;
        int          lat;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic [31:0] last_douta = '0;

    always @(posedge clka) cyc <= cyc + 1;

    always @(negedge clka) begin
        exp_t e;
        if (!rsta && done) begin
            done_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no completion", cyc);
            end else begin
                e = sb.pop_front();
                checks += 2;
                if (err !== e.err) begin
                    errors++;
                    $display("FAIL %s_err: got %b, expected %b", e.name, err, e.err);
                end
                if (douta !== e.data) begin
                    errors++;
                    $display("FAIL %s_data: got %h, expected %h", e.name, douta, e.data);
                end
                if (cyc - e.acc !== e.lat) begin
                    errors++;
                    $display("FAIL %s_latency: got %0d, expected %0d", e.name, cyc - e.acc, e.lat);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 20) begin
            @(negedge clka);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=%b after %0d cycles, expected 1", ready, n);
        end
    endtask

    // Issue one request; expected completion is queued at the acceptance edge.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [11:0] a, input logic [31:0] d,
                          input logic e_err, input logic [31:0] e_data,
                          input string name, input logic keep);
        exp_t e;
        wait_ready();
        we = w; size = sz; sext = sx; addra = a; dina = d; req = 1'b1;
        @(posedge clka);
        #1;
        e.err  = e_err;
        e.name = name;
        e.acc  = cyc;
        if (e_err) begin
            e.data = 32'h0;
            e.lat  = 1;
        end else if (w) begin
            e.data = last_douta;
            e.lat  = 1;
        end else begin
            e.data = e_data;
            e.lat  = TB_LAT;
        end
        last_douta = e.data;
        sb.push_back(e);
        if (!keep) req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clka);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d completions outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clka);
    endtask

    task automatic xfer(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [11:0] a, input logic [31:0] d,
                        input logic e_err, input logic [31:0] e_data, input string name);
        do_req(w, sz, sx, a, d, e_err, e_data, name, 1'b0);
        drain();
    endtask

    task automatic test_reset();
        #1;
        checks += 4;
        if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, expected 1", ready); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, expected 0", done); end
        if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, expected 0", err); end
        if (douta !== 32'h0) begin errors++; $display("FAIL rst_douta: got %h, expected 0", douta); end
        @(negedge clka);
        rsta = 1'b0;
        @(negedge clka);
    endtask

    task automatic test_word();
        xfer(1'b1, 2'b10, 1'b0, 12'h008, 32'hDEADBEEF, 1'b0, 32'h0, "word_store");
        xfer(1'b0, 2'b10, 1'b0, 12'h008, 32'h0, 1'b0, 32'hDEADBEEF, "word_load");
    endtask

    task automatic test_byte_lanes();
        xfer(1'b1, 2'b10, 1'b0, 12'h008, 32'h11223344, 1'b0, 32'h0, "lane_init");
        xfer(1'b1, 2'b00, 1'b0, 12'h00B, 32'hFFFFFF80, 1'b0, 32'h0, "byte_store");
        xfer(1'b0, 2'b10, 1'b0, 12'h008, 32'h0, 1'b0, 32'h80223344, "byte_word_load");
        xfer(1'b0, 2'b00, 1'b1, 12'h00B, 32'h0, 1'b0, 32'hFFFFFF80, "byte_sext");
        xfer(1'b0, 2'b00, 1'b0, 12'h00B, 32'h0, 1'b0, 32'h00000080, "byte_zext");
        xfer(1'b0, 2'b00, 1'b1, 12'h009, 32'h0, 1'b0, 32'h00000033, "byte_lane1");
    endtask

    task automatic test_half();
        xfer(1'b1, 2'b10, 1'b0, 12'h004, 32'h12345678, 1'b0, 32'h0, "half_init");
        xfer(1'b1, 2'b01, 1'b0, 12'h006, 32'h0000A5A5, 1'b0, 32'h0, "half_store");
        xfer(1'b0, 2'b01, 1'b1, 12'h006, 32'h0, 1'b0, 32'hFFFFA5A5, "half_sext");
        xfer(1'b0, 2'b01, 1'b1, 12'h004, 32'h0, 1'b0, 32'h00005678, "half_low");
        xfer(1'b0, 2'b10, 1'b0, 12'h004, 32'h0, 1'b0, 32'hA5A55678, "half_word");
    endtask

    task automatic test_misalign();
        xfer(1'b1, 2'b10, 1'b0, 12'h000, 32'hCAFEF00D, 1'b0, 32'h0, "mis_init");
        xfer(1'b0, 2'b10, 1'b0, 12'h000, 32'h0, 1'b0, 32'hCAFEF00D, "mis_prime");
        xfer(1'b0, 2'b01, 1'b1, 12'h003, 32'h0, 1'b1, 32'h0, "mis_half_load");
        xfer(1'b1, 2'b10, 1'b0, 12'h002, 32'hFFFFFFFF, 1'b1, 32'h0, "mis_word_store");
        xfer(1'b0, 2'b10, 1'b0, 12'h000, 32'h0, 1'b0, 32'hCAFEF00D, "mis_word0");
        xfer(1'b0, 2'b10, 1'b0, 12'h004, 32'h0, 1'b0, 32'hA5A55678, "mis_word4");
        xfer(1'b0, 2'b11, 1'b0, 12'h000, 32'h0, 1'b1, 32'h0, "size_d_illegal");
        xfer(1'b0, 2'b00, 1'b0, 12'h004, 32'h0, 1'b0, 32'h00000078, "err_clears");
    endtask

    task automatic test_back_to_back();
        int acc[4];
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < 4; k++) begin
            do_req(1'b1, 2'b10, 1'b0, 12'(12'h010 + 4 * k), 32'h1000_0000 + 32'(k * 17),
                   1'b0, 32'h0, "b2b_store", 1'b1);
            acc[k] = cyc;
            @(negedge clka);
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready_low: got %b, expected 0 after acceptance %0d", ready, k);
            end
        end
        req = 1'b0;
        drain();
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (acc[k] - acc[k-1] !== 2) begin
                errors++;
                $display("FAIL b2b_interval: got %0d cycles, expected 2", acc[k] - acc[k-1]);
            end
        end
        checks++;
        if (done_cnt - d0 !== 4) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d, expected 4", done_cnt - d0);
        end
        for (int k = 0; k < 4; k++) begin
            xfer(1'b0, 2'b10, 1'b0, 12'(12'h010 + 4 * k), 32'h0, 1'b0,
                 32'h1000_0000 + 32'(k * 17), "b2b_readback");
        end
    endtask

    task automatic test_reset_mid_load();
        int d0;
        do_req(1'b0, 2'b10, 1'b0, 12'h008, 32'h0, 1'b0, 32'h80223344, "abort_load", 1'b0);
        #2 rsta = 1'b1;
        #1;
        sb.delete();
        last_douta = 32'h0;
        checks += 3;
        if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b, expected 1", ready); end
        if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b, expected 0", done); end
        if (douta !== 32'h0) begin errors++; $display("FAIL abort_douta: got %h, expected 0", douta); end
        @(negedge clka);
        rsta = 1'b0;
        d0 = done_cnt;
        repeat (6) @(negedge clka);
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses, expected 0", done_cnt - d0);
        end
        xfer(1'b0, 2'b10, 1'b0, 12'h004, 32'h0, 1'b0, 32'hA5A55678, "after_abort");
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_lanes();
        test_half();
        test_misalign();
        test_back_to_back();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/kgp_data_mem_ctrl.md
# kgp_data_mem_ctrl

Parametrised single-port data memory with a request/done handshake for the KGP-RISC load/store path. Supports byte, half, word and (for 64-bit data) double accesses, with per-lane write enables, sign/zero extension on loads, misalignment detection and a programmable read latency of 1 to 4 cycles. It sits between the execute stage and the on-chip data RAM and replaces the fixed 32-bit word-only memory.

## Interface
- `DATA_W`, 32: data width; 32 or 64 only. `NB = DATA_W/8` byte lanes, `OFF_W = log2(NB)`.
- `DEPTH_W`, 10: log2 of the word count; memory holds `2**DEPTH_W` words of `DATA_W`.
- `RD_LAT`, 1: cycles from acceptance to `done` for loads; legal range 1..4.
- `clka` input 1: clock, rising edge.
- `rsta` input 1: asynchronous active-high reset.
- `req` input 1: request valid; sampled only while `ready`=1.
- `we` input 1: 1 = store, 0 = load.
- `size` input 2: 00 byte, 01 half, 10 word, 11 double (legal only when `DATA_W`=64).
- `sext` input 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `addra` input `DEPTH_W+OFF_W`: byte address; upper `DEPTH_W` bits select the word, low `OFF_W` bits the lane.
- `dina` input `DATA_W`: store data, right-aligned (bits [8·n-1:0] used for an n-byte access).
- `ready` output 1: controller idle, can accept.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: valid with `done`; 1 = misaligned or illegal size.
- `douta` output `DATA_W`: load result, valid with `done`, held until next `done`.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE: `ready`=1. On `req`=1, latch `we`, `size`, `sext`, `addra`, `dina` and go to WAIT (RESP if `RD_LAT`=1 or the access is a store or an error).
- WAIT: internal counter counts `RD_LAT-1` cycles, then RESP. `ready`=0.
- RESP: `done`=1 for exactly one cycle, then IDLE. `ready`=0 in RESP. A back-to-back request is accepted the cycle after RESP.
- Access length n = 1, 2, 4, 8 bytes for size 00..11. Misaligned when `addra mod n` ≠ 0. Illegal when size=11 with `DATA_W`=32.
- Error accesses: memory untouched, `err`=1, `douta` set to 0, complete with a 1-cycle latency.
- Store: lane mask = n contiguous ones shifted left by `addra[OFF_W-1:0]`. `dina` is shifted to the same lanes. Written on the acceptance edge. Unmasked lanes are preserved, with no read-modify-write. `douta` is unchanged. `done` follows the next cycle.
- Load: the RAM word is read at acceptance. The selected lanes are shifted to bit 0 and extended to `DATA_W` per `sext`. A full-width access ignores `sext`.
- Memory contents are not cleared by reset and are undefined at power-up.
- Reset during WAIT or RESP aborts the access. No `done` is issued. A store already committed at acceptance stays committed.

## Timing
- Reset values: `ready`=1, `done`=0, `err`=0, `douta`=0, FSM=IDLE, counter=0.
- Store latency: 1 cycle, acceptance edge to `done`.
- Load latency: `RD_LAT` cycles. `douta` and `err` are registered and change only on the edge that raises `done`.
- Throughput: one access per `latency+1` cycles. `req` while `ready`=0 is ignored and not queued.
- Inputs need only be stable at the acceptance edge.

## Structure
- Shared package `kgp_mem_pkg` holds the `size` encodings (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`), the FSM state encoding, and a function that returns the byte length for a size.
- Sub-module `kgp_mem_array` is a plain single-port RAM with a per-lane write mask and a registered read, parametrised by `DATA_W`/`DEPTH_W`.
- The controller holds the FSM, the latency counter, alignment checking, lane shifting and extension.

## Test plan
- Reset: assert `rsta` mid-load with `RD_LAT`=3 → `ready`=1, `done`=0 and `douta`=0 immediately; no `done` follows.
- Word store then load: store 0xDEADBEEF at 0x008, then load word 0x008 with `RD_LAT`=2 → `done` 2 cycles after acceptance, `douta`=0xDEADBEEF, `err`=0.
- Byte lanes: store byte 0x80 at 0x00B over word 0x11223344, then load the word → 0x80223344. Load byte 0x00B with `sext`=1 → 0xFFFFFF80; with `sext`=0 → 0x00000080.
- Half store and load: store half 0xA5A5 at 0x006, then load half with `sext`=1 → 0xFFFFA5A5. Bytes 0x004–0x005 are unchanged.
- Misalignment: load half at 0x003 → `done` after 1 cycle, `err`=1, `douta`=0. Store word at 0x002 → `err`=1 and a following read of words 0x000 and 0x004 shows them unchanged. Size 11 with `DATA_W`=32 → `err`=1.
- Handshake: hold `req`=1 continuously for 4 stores → accepted one every 2 cycles, `ready`=0 between acceptances, and exactly 4 `done` pulses.
